// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential/relative/absolute flow control plus a
// bounded return-address stack with a sticky overflow/underflow fault flag.
module pc_sequencer #(
  parameter int unsigned   D         = 12,
  parameter int unsigned   DEPTH     = 4,
  parameter logic [D-1:0]  RESET_VEC = {D{1'b0}}
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req,
  input  logic [2:0]                 op,
  input  logic                       cond,
  input  logic [D-1:0]               offset,
  input  logic [D-1:0]               target,
  output logic [D-1:0]               prog_ctr,
  output logic [$clog2(DEPTH+1)-1:0] sp,
  output logic                       stack_empty,
  output logic                       stack_full,
  output logic                       fault
);

  localparam int unsigned SPW = $clog2(DEPTH + 1);
  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  localparam logic [2:0] OP_SEQ  = 3'b000;
  localparam logic [2:0] OP_RJMP = 3'b001;
  localparam logic [2:0] OP_AJMP = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;

  logic [D-1:0]   stack_r [DEPTH];
  logic [D-1:0]   pc_inc_s;
  logic [D-1:0]   pc_next_s;
  logic [SPW-1:0] sp_next_s;
  logic           fault_next_s;
  logic           push_s;
  logic [AW-1:0]  push_idx_s;
  logic [AW-1:0]  pop_idx_s;

  assign stack_empty = (sp == {SPW{1'b0}});
  assign stack_full  = (sp == SP_FULL);
  assign pc_inc_s    = prog_ctr + {{(D-1){1'b0}}, 1'b1};
  // Indices only matter when the stack is not full (push) / not empty (pop).
  assign push_idx_s  = sp[AW-1:0];
  assign pop_idx_s   = push_idx_s - {{(AW-1){1'b0}}, 1'b1};

  // Next-state decode for program counter, stack pointer and fault flag.
  always_comb begin
    pc_next_s    = pc_inc_s;
    sp_next_s    = sp;
    fault_next_s = fault;
    push_s       = 1'b0;
    case (op)
      OP_SEQ: begin
        pc_next_s = pc_inc_s;
      end
      OP_RJMP: begin
        if (cond && (offset != {D{1'b0}})) begin
          pc_next_s = prog_ctr + offset;
        end else begin
          pc_next_s = pc_inc_s;
        end
      end
      OP_AJMP: begin
        if (cond) begin
          pc_next_s = target;
        end else begin
          pc_next_s = pc_inc_s;
        end
      end
      OP_CALL: begin
        if (!stack_full) begin
          push_s    = 1'b1;
          sp_next_s = sp + {{(SPW-1){1'b0}}, 1'b1};
          pc_next_s = prog_ctr + offset;
        end else begin
          fault_next_s = 1'b1;
        end
      end
      OP_RET: begin
        if (!stack_empty) begin
          sp_next_s = sp - {{(SPW-1){1'b0}}, 1'b1};
          pc_next_s = stack_r[pop_idx_s];
        end else begin
          fault_next_s = 1'b1;
        end
      end
      default: begin
        pc_next_s = pc_inc_s;
      end
    endcase
  end

  // Architectural state: reset dominates, otherwise advance only on req.
  always_ff @(posedge clk) begin
    if (reset) begin
      prog_ctr <= RESET_VEC;
      sp       <= {SPW{1'b0}};
      fault    <= 1'b0;
    end else if (req) begin
      prog_ctr <= pc_next_s;
      sp       <= sp_next_s;
      fault    <= fault_next_s;
    end else begin
      prog_ctr <= prog_ctr;
      sp       <= sp;
      fault    <= fault;
    end
  end

  // Return-address storage; contents above sp are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (!reset && req && push_s) begin
      stack_r[push_idx_s] <= pc_inc_s;
    end else begin
      stack_r[push_idx_s] <= stack_r[push_idx_s];
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (D=12, DEPTH=4): per-scenario stimulus tables
// with hand-computed expected prog_ctr / sp / fault after each clock.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        req;
  logic [2:0]  op;
  logic        cond;
  logic [11:0] offset;
  logic [11:0] target;
  logic [11:0] prog_ctr;
  logic [2:0]  sp;
  logic        stack_empty;
  logic        stack_full;
  logic        fault;

  int pass_cnt  = 0;
  int total_cnt = 0;

  localparam logic [2:0] SEQ  = 3'b000;
  localparam logic [2:0] RJMP = 3'b001;
  localparam logic [2:0] AJMP = 3'b010;
  localparam logic [2:0] CALL = 3'b011;
  localparam logic [2:0] RET  = 3'b100;

  typedef struct {
    logic        rst;
    logic        rq;
    logic [2:0]  op;
    logic        cnd;
    logic [11:0] off;
    logic [11:0] tgt;
    logic [11:0] pc;
    logic [2:0]  sp;
    logic        flt;
  } vec_t;

  vec_t q[$];

  pc_sequencer #(.D(12), .DEPTH(4), .RESET_VEC(12'h000)) dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .cond(cond),
    .offset(offset), .target(target), .prog_ctr(prog_ctr), .sp(sp),
    .stack_empty(stack_empty), .stack_full(stack_full), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic rst, input logic rq, input logic [2:0] o,
                              input logic c, input logic [11:0] off, input logic [11:0] tgt,
                              input logic [11:0] pc, input logic [2:0] s, input logic f);
    vec_t v;
    v.rst = rst; v.rq = rq; v.op = o; v.cnd = c; v.off = off; v.tgt = tgt;
    v.pc = pc; v.sp = s; v.flt = f;
    q.push_back(v);
  endfunction

  task automatic apply(input vec_t v);
    reset  = v.rst;
    req    = v.rq;
    op     = v.op;
    cond   = v.cnd;
    offset = v.off;
    target = v.tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    q.delete();
    add(1'b1, 1'b1, CALL, 1'b1, 12'h010, 12'h000, 12'h000, 3'd0, 1'b0);
    add(1'b1, 1'b0, SEQ,  1'b0, 12'h000, 12'h000, 12'h000, 3'd0, 1'b0);
    foreach (q[i]) begin
      apply(q[i]);
      total_cnt++;
      if ({prog_ctr, sp, stack_empty, stack_full, fault} !==
          {q[i].pc, q[i].sp, q[i].sp == 3'd0, q[i].sp == 3'd4, q[i].flt}) begin
        $display("FAIL reset[%0d] got pc=%h sp=%0d e=%b f=%b flt=%b want pc=%h sp=%0d flt=%b",
                 i, prog_ctr, sp, stack_empty, stack_full, fault, q[i].pc, q[i].sp, q[i].flt);
      end else begin
        pass_cnt++;
      end
    end
  endtask

  task automatic test_seq_hold();
    q.delete();
    add(1'b0, 1'b1, SEQ,  1'b0, 12'h000, 12'h000, 12'h001, 3'd0, 1'b0);
    add(1'b0, 1'b1, SEQ,  1'b0, 12'h000, 12'h000, 12'h002, 3'd0, 1'b0);
    add(1'b0, 1'b1, SEQ,  1'b0, 12'h000, 12'h000, 12'h003, 3'd0, 1'b0);
    add(1'b0, 1'b0, SEQ,  1'b0, 12'h000, 12'h000, 12'h003, 3'd0, 1'b0);
    add(1'b0, 1'b0, CALL, 1'b1, 12'h055, 12'h000, 12'h003, 3'd0, 1'b0);
    add(1'b0, 1'b0, RET,  1'b1, 12'h000, 12'h000, 12'h003, 3'd0, 1'b0);
    foreach (q[i]) begin
      apply(q[i]);
      total_cnt++;
      if ({prog_ctr, sp, stack_empty, stack_full, fault} !==
          {q[i].pc, q[i].sp, q[i].sp == 3'd0, q[i].sp == 3'd4, q[i].flt}) begin
        $display("FAIL seq_hold[%0d] got pc=%h sp=%0d e=%b f=%b flt=%b want pc=%h sp=%0d flt=%b",
                 i, prog_ctr, sp, stack_empty, stack_full, fault, q[i].pc, q[i].sp, q[i].flt);
      end else begin
        pass_cnt++;
      end
    end
  endtask

  task automatic test_jumps();
    q.delete();
    add(1'b0, 1'b1, AJMP, 1'b1, 12'h000, 12'h00A, 12'h00A, 3'd0, 1'b0);
    add(1'b0, 1'b1, RJMP, 1'b1, 12'hFFE, 12'h000, 12'h008, 3'd0, 1'b0);
    add(1'b0, 1'b1, RJMP, 1'b0, 12'h005, 12'h000, 12'h009, 3'd0, 1'b0);
    add(1'b0, 1'b1, RJMP, 1'b1, 12'h000, 12'h000, 12'h00A, 3'd0, 1'b0);
    add(1'b0, 1'b1, RJMP, 1'b1, 12'h100, 12'h000, 12'h10A, 3'd0, 1'b0);
    add(1'b0, 1'b1, AJMP, 1'b1, 12'h000, 12'hFFE, 12'hFFE, 3'd0, 1'b0);
    add(1'b0, 1'b1, SEQ,  1'b0, 12'h000, 12'h000, 12'hFFF, 3'd0, 1'b0);
    add(1'b0, 1'b1, SEQ,  1'b0, 12'h000, 12'h000, 12'h000, 3'd0, 1'b0);
    add(1'b0, 1'b1, AJMP, 1'b1, 12'h000, 12'h123, 12'h123, 3'd0, 1'b0);
    add(1'b0, 1'b1, AJMP, 1'b0, 12'h000, 12'h777, 12'h124, 3'd0, 1'b0);
    add(1'b0, 1'b1, 3'b101, 1'b1, 12'h040, 12'h777, 12'h125, 3'd0, 1'b0);
    add(1'b0, 1'b1, 3'b111, 1'b1, 12'h040, 12'h777, 12'h126, 3'd0, 1'b0);
    add(1'b0, 1'b1, AJMP, 1'b1, 12'h000, 12'hFFD, 12'hFFD, 3'd0, 1'b0);
    add(1'b0, 1'b1, RJMP, 1'b1, 12'h005, 12'h000, 12'h002, 3'd0, 1'b0);
    foreach (q[i]) begin
      apply(q[i]);
      total_cnt++;
      if ({prog_ctr, sp, stack_empty, stack_full, fault} !==
          {q[i].pc, q[i].sp, q[i].sp == 3'd0, q[i].sp == 3'd4, q[i].flt}) begin
        $display("FAIL jumps[%0d] got pc=%h sp=%0d e=%b f=%b flt=%b want pc=%h sp=%0d flt=%b",
                 i, prog_ctr, sp, stack_empty, stack_full, fault, q[i].pc, q[i].sp, q[i].flt);
      end else begin
        pass_cnt++;
      end
    end
  endtask

  task automatic test_call_ret();
    q.delete();
    add(1'b0, 1'b1, AJMP, 1'b1, 12'h000, 12'h020, 12'h020, 3'd0, 1'b0);
    add(1'b0, 1'b1, CALL, 1'b0, 12'h010, 12'h000, 12'h030, 3'd1, 1'b0);
    add(1'b0, 1'b1, CALL, 1'b1, 12'h010, 12'h000, 12'h040, 3'd2, 1'b0);
    add(1'b0, 1'b1, RET,  1'b0, 12'h000, 12'h000, 12'h031, 3'd1, 1'b0);
    add(1'b0, 1'b1, RET,  1'b1, 12'h000, 12'h000, 12'h021, 3'd0, 1'b0);
    foreach (q[i]) begin
      apply(q[i]);
      total_cnt++;
      if ({prog_ctr, sp, stack_empty, stack_full, fault} !==
          {q[i].pc, q[i].sp, q[i].sp == 3'd0, q[i].sp == 3'd4, q[i].flt}) begin
        $display("FAIL call_ret[%0d] got pc=%h sp=%0d e=%b f=%b flt=%b want pc=%h sp=%0d flt=%b",
                 i, prog_ctr, sp, stack_empty, stack_full, fault, q[i].pc, q[i].sp, q[i].flt);
      end else begin
        pass_cnt++;
      end
    end
  endtask

  task automatic test_overflow_underflow();
    q.delete();
    add(1'b0, 1'b1, CALL, 1'b0, 12'h100, 12'h000, 12'h121, 3'd1, 1'b0);
    add(1'b0, 1'b1, CALL, 1'b0, 12'h100, 12'h000, 12'h221, 3'd2, 1'b0);
    add(1'b0, 1'b1, CALL, 1'b0, 12'h100, 12'h000, 12'h321, 3'd3, 1'b0);
    add(1'b0, 1'b1, CALL, 1'b0, 12'h100, 12'h000, 12'h421, 3'd4, 1'b0);
    add(1'b0, 1'b1, CALL, 1'b0, 12'h100, 12'h000, 12'h422, 3'd4, 1'b1);
    add(1'b0, 1'b1, RET,  1'b0, 12'h000, 12'h000, 12'h322, 3'd3, 1'b1);
    add(1'b0, 1'b1, RET,  1'b0, 12'h000, 12'h000, 12'h222, 3'd2, 1'b1);
    add(1'b0, 1'b1, RET,  1'b0, 12'h000, 12'h000, 12'h122, 3'd1, 1'b1);
    add(1'b0, 1'b1, RET,  1'b0, 12'h000, 12'h000, 12'h022, 3'd0, 1'b1);
    add(1'b0, 1'b1, RET,  1'b0, 12'h000, 12'h000, 12'h023, 3'd0, 1'b1);
    add(1'b0, 1'b1, SEQ,  1'b0, 12'h000, 12'h000, 12'h024, 3'd0, 1'b1);
    add(1'b0, 1'b1, CALL, 1'b0, 12'hFF0, 12'h000, 12'h014, 3'd1, 1'b1);
    add(1'b0, 1'b1, RET,  1'b0, 12'h000, 12'h000, 12'h025, 3'd0, 1'b1);
    foreach (q[i]) begin
      apply(q[i]);
      total_cnt++;
      if ({prog_ctr, sp, stack_empty, stack_full, fault} !==
          {q[i].pc, q[i].sp, q[i].sp == 3'd0, q[i].sp == 3'd4, q[i].flt}) begin
        $display("FAIL ovf_unf[%0d] got pc=%h sp=%0d e=%b f=%b flt=%b want pc=%h sp=%0d flt=%b",
                 i, prog_ctr, sp, stack_empty, stack_full, fault, q[i].pc, q[i].sp, q[i].flt);
      end else begin
        pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_mid_op();
    q.delete();
    add(1'b1, 1'b0, SEQ,  1'b0, 12'h000, 12'h000, 12'h000, 3'd0, 1'b0);
    add(1'b0, 1'b1, RET,  1'b0, 12'h000, 12'h000, 12'h001, 3'd0, 1'b1);
    add(1'b0, 1'b1, CALL, 1'b0, 12'h000, 12'h000, 12'h001, 3'd1, 1'b1);
    add(1'b0, 1'b1, CALL, 1'b0, 12'h000, 12'h000, 12'h001, 3'd2, 1'b1);
    add(1'b0, 1'b1, CALL, 1'b0, 12'h000, 12'h000, 12'h001, 3'd3, 1'b1);
    add(1'b1, 1'b1, CALL, 1'b1, 12'h050, 12'h000, 12'h000, 3'd0, 1'b0);
    add(1'b0, 1'b1, RET,  1'b0, 12'h000, 12'h000, 12'h001, 3'd0, 1'b1);
    foreach (q[i]) begin
      apply(q[i]);
      total_cnt++;
      if ({prog_ctr, sp, stack_empty, stack_full, fault} !==
          {q[i].pc, q[i].sp, q[i].sp == 3'd0, q[i].sp == 3'd4, q[i].flt}) begin
        $display("FAIL reset_mid[%0d] got pc=%h sp=%0d e=%b f=%b flt=%b want pc=%h sp=%0d flt=%b",
                 i, prog_ctr, sp, stack_empty, stack_full, fault, q[i].pc, q[i].sp, q[i].flt);
      end else begin
        pass_cnt++;
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    req    = 1'b0;
    op     = SEQ;
    cond   = 1'b0;
    offset = 12'h000;
    target = 12'h000;
    @(negedge clk);
    test_reset();
    test_seq_hold();
    test_jumps();
    test_call_ret();
    test_overflow_underflow();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
